// File: rtl/ifetch_unit.sv
// ---------------------------------------------------------------------------
// ifetch_unit
//
// Instruction-fetch stage that sits directly ahead of the single-cycle
// controller/datapath. It owns the architectural PC and fetches one
// instruction at a time from a variable-latency instruction memory. It holds
// the returned word stable for decode until the core retires it, then picks
// the next PC from PCSrc/PCTarget.
//
// Handshake: a fetch is offered while imem_req is high, and imem_addr (= PC)
// is held stable until imem_gnt is seen. Exactly one response is then
// expected; imem_rvalid qualifies imem_rdata. A response that does not
// arrive within MAX_WAIT cycles of the grant is a bus error. On the core side,
// instr_valid marks Instr/PC as decodable, and advance in a valid cycle
// retires the instruction.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   PCSrc, PCTarget            next-PC select (1 = target, 0 = PC+4)
//   advance                    core retires the held instruction
//   imem_req, imem_addr        fetch request / address (always PC)
//   imem_gnt                   request accepted
//   imem_rvalid, imem_rdata    response valid / instruction word
//   PC, PCPlus4                current PC and PC+4 (wraps mod 2^32)
//   Instr, instr_valid         held instruction and its valid flag
//   misaligned_fault           sticky: retired to a target with [1:0] != 0
//   bus_error                  sticky: response timeout
//   dbg_state                  current FSM state (0 FETCH, 1 WAIT, 2 READY, 3 HALT)
// ---------------------------------------------------------------------------
module ifetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned MAX_WAIT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        PCSrc,
    input  logic [31:0] PCTarget,
    input  logic        advance,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] PC,
    output logic [31:0] PCPlus4,
    output logic [31:0] Instr,
    output logic        instr_valid,
    output logic        misaligned_fault,
    output logic        bus_error,
    output logic [1:0]  dbg_state
);

    localparam logic [31:0] NOP       = 32'h0000_0013;
    // Last counter value at which the WAIT state may still see a response.
    localparam logic [7:0]  WAIT_LAST = 8'(MAX_WAIT - 1);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_WAIT  = 2'd1,
        S_READY = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        mis_q, mis_d;
    logic        berr_q, berr_d;
    logic [31:0] pc_plus4;

    assign pc_plus4 = pc_q + 32'd4;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            pc_q    <= RESET_PC;
            instr_q <= NOP;
            cnt_q   <= '0;
            mis_q   <= 1'b0;
            berr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            cnt_q   <= cnt_d;
            mis_q   <= mis_d;
            berr_q  <= berr_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        instr_d     = instr_q;
        cnt_d       = cnt_q;
        mis_d       = mis_q;
        berr_d      = berr_q;
        imem_req    = 1'b0;
        instr_valid = 1'b0;

        case (state_q)
            S_FETCH: begin
                // The reset cycle itself must not present a request.
                imem_req = !reset;
                if (imem_gnt) begin
                    state_d = S_WAIT;
                    cnt_d   = '0;
                end
            end
            S_WAIT: begin
                // A response in the final allowed cycle still wins over the timeout.
                if (imem_rvalid) begin
                    instr_d = imem_rdata;
                    state_d = S_READY;
                end else if (cnt_q == WAIT_LAST) begin
                    berr_d  = 1'b1;
                    state_d = S_HALT;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_READY: begin
                instr_valid = !reset;
                if (advance) begin
                    if (!PCSrc) begin
                        pc_d    = pc_plus4;
                        state_d = S_FETCH;
                    end else if (PCTarget[1:0] == 2'b00) begin
                        pc_d    = PCTarget;
                        state_d = S_FETCH;
                    end else begin
                        // PC stays on the faulting instruction for post-mortem.
                        mis_d   = 1'b1;
                        state_d = S_HALT;
                    end
                end
            end
            default: begin
                // S_HALT: frozen until reset.
            end
        endcase
    end

    assign imem_addr        = pc_q;
    assign PC               = pc_q;
    assign PCPlus4          = pc_plus4;
    assign Instr            = instr_q;
    assign misaligned_fault = mis_q;
    assign bus_error        = berr_q;
    assign dbg_state        = state_q;

endmodule

// File: tb/tb_ifetch_unit.sv
module tb_ifetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          MAX_WAIT = 16;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk;
  logic        reset;
  logic        PCSrc;
  logic [31:0] PCTarget;
  logic        advance;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] PC;
  logic [31:0] PCPlus4;
  logic [31:0] Instr;
  logic        instr_valid;
  logic        misaligned_fault;
  logic        bus_error;
  logic [1:0]  dbg_state;

  int n_tests;
  int n_fail;

  // Scoreboard: addresses the core is expected to fetch next, in order.
  logic [31:0] exp_q[$];
  // Last instruction word delivered by memory (what Instr must hold).
  logic [31:0] m_instr;

  ifetch_unit #(
    .RESET_PC(RESET_PC),
    .MAX_WAIT(MAX_WAIT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .PCSrc(PCSrc),
    .PCTarget(PCTarget),
    .advance(advance),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata),
    .PC(PC),
    .PCPlus4(PCPlus4),
    .Instr(Instr),
    .instr_valid(instr_valid),
    .misaligned_fault(misaligned_fault),
    .bus_error(bus_error),
    .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- memory contents ----------------
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    advance     = 1'b0;
    tick();
    check("rst_pc_1", PC, RESET_PC);
    check("rst_valid_1", 32'(instr_valid), 32'd0);
    tick();
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_pc", PC, RESET_PC);
    check("rst_instr", Instr, NOP);
    check("rst_mis", 32'(misaligned_fault), 32'd0);
    check("rst_berr", 32'(bus_error), 32'd0);
    reset = 1'b0;
    #1;
    m_instr = NOP;
    exp_q.delete();
    exp_q.push_back(RESET_PC);
  endtask

  // Hold off the grant for g cycles, then grant. Returns the fetched address.
  task automatic fetch_grant(input int g, output logic [31:0] cur);
    cur = exp_q.pop_front();
    for (int i = 0; i < g; i++) begin
      check("stall_req", 32'(imem_req), 32'd1);
      check("stall_addr", imem_addr, cur);
      check("stall_valid", 32'(instr_valid), 32'd0);
      advance = 1'($urandom_range(0, 1));
      PCSrc   = 1'($urandom_range(0, 1));
      tick();
    end
    check("fetch_req", 32'(imem_req), 32'd1);
    check("fetch_addr", imem_addr, cur);
    check("fetch_pc", PC, cur);
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    advance  = 1'b0;
  endtask

  // Respond d cycles after the first WAIT cycle, then check the held instruction.
  task automatic wait_resp(input int d, input logic [31:0] cur);
    for (int i = 0; i < d; i++) begin
      check("wait_req", 32'(imem_req), 32'd0);
      check("wait_valid", 32'(instr_valid), 32'd0);
      check("wait_pc", PC, cur);
      advance = 1'($urandom_range(0, 1));
      tick();
    end
    check("wait_berr", 32'(bus_error), 32'd0);
    imem_rvalid = 1'b1;
    imem_rdata  = mem_word(cur);
    advance     = 1'($urandom_range(0, 1));
    tick();
    imem_rvalid = 1'b0;
    imem_rdata  = $urandom();
    advance     = 1'b0;
    m_instr     = mem_word(cur);
    check("rdy_valid", 32'(instr_valid), 32'd1);
    check("rdy_instr", Instr, m_instr);
    check("rdy_pc", PC, cur);
    check("rdy_pc4", PCPlus4, cur + 32'd4);
  endtask

  // Hold for h cycles, then retire. halted = 1 when the target was misaligned.
  task automatic retire(input int h, input logic src, input logic [31:0] tgt,
                        input logic [31:0] cur, output logic halted);
    logic [31:0] nxt;
    for (int i = 0; i < h; i++) begin
      PCSrc    = 1'($urandom_range(0, 1));
      PCTarget = $urandom();
      tick();
      check("hold_valid", 32'(instr_valid), 32'd1);
      check("hold_instr", Instr, m_instr);
      check("hold_pc", PC, cur);
    end
    PCSrc    = src;
    PCTarget = tgt;
    advance  = 1'b1;
    tick();
    advance  = 1'b0;
    halted   = src && (tgt[1:0] != 2'b00);
    check("ret_valid", 32'(instr_valid), 32'd0);
    if (halted) begin
      check("mis_flag", 32'(misaligned_fault), 32'd1);
      for (int i = 0; i < 3; i++) begin
        check("halt_req", 32'(imem_req), 32'd0);
        check("halt_pc", PC, cur);
        check("halt_valid", 32'(instr_valid), 32'd0);
        imem_gnt = 1'($urandom_range(0, 1));
        advance  = 1'($urandom_range(0, 1));
        tick();
      end
      imem_gnt = 1'b0;
      advance  = 1'b0;
      check("halt_mis_sticky", 32'(misaligned_fault), 32'd1);
    end else begin
      nxt = src ? tgt : cur + 32'd4;
      check("ret_mis", 32'(misaligned_fault), 32'd0);
      exp_q.push_back(nxt);
    end
  endtask

  // No response ever arrives: bus error must appear exactly MAX_WAIT cycles after the grant.
  task automatic timeout(input logic [31:0] cur);
    for (int i = 0; i < MAX_WAIT; i++) begin
      check("to_berr_early", 32'(bus_error), 32'd0);
      check("to_valid", 32'(instr_valid), 32'd0);
      tick();
    end
    check("to_berr", 32'(bus_error), 32'd1);
    imem_rvalid = 1'b1;
    imem_rdata  = $urandom();
    tick();
    imem_rvalid = 1'b0;
    check("to_late_valid", 32'(instr_valid), 32'd0);
    check("to_late_instr", Instr, m_instr);
    check("to_req", 32'(imem_req), 32'd0);
    check("to_pc", PC, cur);
  endtask

  // One complete fetch/retire transaction. kind: 0 normal, 1 timeout, 2 reset during WAIT.
  task automatic run_txn(input int kind, input int g, input int d, input int h,
                         input logic src, input logic [31:0] tgt);
    logic [31:0] cur;
    logic        halted;
    fetch_grant(g, cur);
    if (kind == 1) begin
      timeout(cur);
      do_reset();
    end else if (kind == 2) begin
      for (int i = 0; i < d; i++) tick();
      do_reset();
    end else begin
      wait_resp(d, cur);
      retire(h, src, tgt, cur, halted);
      if (halted) do_reset();
    end
  endtask

  // ---------------- stimulus ----------------
  int          dg[6]  = '{0, 0, 4, 0, 0, 0};
  int          dd[6]  = '{0, 0, 5, 0, 0, 0};
  logic        ds[6]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
  logic [31:0] dt[6]  = '{32'h0, 32'h0, 32'h10, 32'h40, 32'hFFFF_FFFC, 32'h0};

  initial begin
    n_tests     = 0;
    n_fail      = 0;
    reset       = 1'b1;
    PCSrc       = 1'b0;
    PCTarget    = 32'h0;
    advance     = 1'b0;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    m_instr     = NOP;

    do_reset();

    // Directed walk: 0 -> 4 -> 8 (stalled) -> 0x10 -> 0x40 -> 0xFFFFFFFC -> wrap to 0.
    for (int i = 0; i < 6; i++) run_txn(0, dg[i], dd[i], 0, ds[i], dt[i]);
    check("wrap_addr", exp_q[0], 32'h0);

    // Misaligned target from PC 0.
    run_txn(0, 0, 0, 0, 1'b1, 32'h22);
    // Timeout, then reset in WAIT, then a response in the last allowed WAIT cycle.
    run_txn(1, 0, 0, 0, 1'b0, 32'h0);
    run_txn(2, 1, 2, 0, 1'b0, 32'h0);
    run_txn(0, 0, MAX_WAIT - 1, 0, 1'b0, 32'h0);

    for (int n = 0; n < 60; n++) begin
      int          kind;
      int          r;
      logic [31:0] tgt;
      r    = $urandom_range(0, 11);
      kind = (r == 0) ? 1 : (r == 1) ? 2 : 0;
      r    = $urandom_range(0, 9);
      if (r == 0)      tgt = ($urandom() & 32'hFFFF_FFFC) | 32'($urandom_range(1, 3));
      else if (r == 1) tgt = 32'hFFFF_FFFC;
      else             tgt = $urandom() & 32'hFFFF_FFFC;
      run_txn(kind,
              $urandom_range(0, 3),
              ($urandom_range(0, 7) == 0) ? MAX_WAIT - 1 : $urandom_range(0, 5),
              $urandom_range(0, 2),
              1'($urandom_range(0, 1)),
              tgt);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
